// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the RV32I multicycle controller: ALU op codes, FSM states,
// opcodes and datapath mux selects.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BRANCH
    } state_e;

    // Class of ALU selection requested by the FSM from alu_decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNC   = 2'b10
    } alu_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation select: fixed add, branch compare, or funct3/funct7-driven
// arithmetic for register and immediate instructions.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    input  logic [1:0] ALUOp,
    output logic [3:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   ALUControl = ALU_SLT;
                    2'b11:   ALUControl = ALU_SLTU;
                    default: ALUControl = ALU_SUB;
                endcase
            end
            ALUOP_FUNC: begin
                case (funct3)
                    // op[5] separates R-type from I-type: addi never subtracts.
                    3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  ALUControl = ALU_SLL;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b011:  ALUControl = ALU_SLTU;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  ALUControl = ALU_OR;
                    default: ALUControl = ALU_AND;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// RV32I multicycle control FSM: Moore state outputs, op-driven ImmSrc,
// Zero-qualified PCWrite in BRANCH, strobes held low during reset.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [3:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IllegalInstr
);

    state_e  state, state_next;
    alu_op_e alu_op;
    logic    ir_w, pc_w, reg_w, mem_w, illegal, branch, taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ResultSrc  = RES_ALUOUT;
        AdrSrc     = 1'b0;
        alu_op     = ALUOP_ADD;
        ir_w       = 1'b0;
        pc_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        illegal    = 1'b0;
        branch     = 1'b0;
        case (state)
            S_FETCH: begin
                AdrSrc     = 1'b0;
                ir_w       = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                pc_w       = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH:         state_next = S_BRANCH;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ResultSrc  = RES_ALUOUT;
                AdrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                ResultSrc  = RES_ALUOUT;
                AdrSrc     = 1'b1;
                mem_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                alu_op     = ALUOP_FUNC;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNC;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALUOUT;
                pc_w       = 1'b1;
                state_next = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ResultSrc  = RES_ALUOUT;
                alu_op     = ALUOP_BRANCH;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Branch condition from the compare result: beq/bge/bgeu take on Zero.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000, 3'b101, 3'b111: taken = Zero;
            3'b001, 3'b100, 3'b110: taken = ~Zero;
            default:                taken = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUOp      (alu_op),
        .ALUControl (ALUControl)
    );

    // State already reads FETCH during reset; only the strobes need gating.
    assign IRWrite      = rst_n & ir_w;
    assign PCWrite      = rst_n & (pc_w | (branch & taken));
    assign RegWrite     = rst_n & reg_w;
    assign MemWrite     = rst_n & mem_w;
    assign IllegalInstr = rst_n & illegal;
    assign ImmSrc       = imm_src(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle tables queued as
// expectations, checked by an independent negedge monitor.
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [2:0] imm;
        logic       adr;
        logic       ir;
        logic       pc;
        logic       rw;
        logic       mw;
        logic       ill;
    } out_t;

    typedef struct {
        out_t  e;
        out_t  m;
        string tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic [3:0] ALUControl;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, IllegalInstr;

    out_t act;
    exp_t q[$];
    exp_t cur;
    bit   mon_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .IllegalInstr(IllegalInstr)
    );

    assign act = {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
                  IRWrite, PCWrite, RegWrite, MemWrite, IllegalInstr};

    always #5 clk = ~clk;

    task automatic cmp(input out_t a, input out_t e, input out_t m, input string tag);
        vectors++;
        if ((a & m) !== (e & m)) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (mask %h)", tag, a & m, e & m, m);
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 3'b001;
        if (o == 7'b1100011) return 3'b010;
        if (o == 7'b1101111) return 3'b011;
        return 3'b000;
    endfunction

    function automatic logic [3:0] alu_ri(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd8;
            3'd2:    return 4'd5;
            3'd3:    return 4'd9;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd7 : 4'd6;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'd0, 3'd5, 3'd7: return z;
            3'd1, 3'd4, 3'd6: return !z;
            default:          return 1'b0;
        endcase
    endfunction

    task automatic push(input out_t e, input out_t m, input string name, inout int n);
        exp_t x;
        n++;
        x.e = e;
        x.m = m;
        x.tag = $sformatf("%s.c%0d", name, n);
        q.push_back(x);
    endtask

    // Cycle table for one instruction; selects not named for a cycle are unchecked.
    task automatic plan(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic [4:0] z, input string name, output int n);
        out_t b, mb, e, m;
        bit   legal;
        legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
                (o == 7'b0010011) || (o == 7'b1101111) || (o == 7'b1100011);
        b = '0;  b.imm = imm_of(o);
        mb = '0; mb.alu = '1; mb.imm = '1;
        mb.ir = 1'b1; mb.pc = 1'b1; mb.rw = 1'b1; mb.mw = 1'b1; mb.ill = 1'b1;
        n = 0;
        e = b; m = mb;
        e.srca = 2'd0; e.srcb = 2'd2; e.res = 2'd2; e.adr = 1'b0; e.ir = 1'b1; e.pc = 1'b1;
        m.srca = '1; m.srcb = '1; m.res = '1; m.adr = 1'b1;
        push(e, m, name, n);
        e = b; m = mb;
        e.srca = 2'd1; e.srcb = 2'd1; m.srca = '1; m.srcb = '1; e.ill = !legal;
        push(e, m, name, n);
        if (o == 7'b0000011 || o == 7'b0100011) begin
            e = b; m = mb; e.srca = 2'd2; e.srcb = 2'd1; m.srca = '1; m.srcb = '1;
            push(e, m, name, n);
            e = b; m = mb; e.res = 2'd0; e.adr = 1'b1; m.res = '1; m.adr = 1'b1;
            e.mw = (o == 7'b0100011);
            push(e, m, name, n);
            if (o == 7'b0000011) begin
                e = b; m = mb; e.res = 2'd1; e.rw = 1'b1; m.res = '1;
                push(e, m, name, n);
            end
        end else if (o == 7'b0110011 || o == 7'b0010011) begin
            e = b; m = mb; e.srca = 2'd2; e.srcb = (o == 7'b0110011) ? 2'd0 : 2'd1;
            m.srca = '1; m.srcb = '1; e.alu = alu_ri(f3, f7, o[5]);
            push(e, m, name, n);
            e = b; m = mb; e.res = 2'd0; e.rw = 1'b1; m.res = '1;
            push(e, m, name, n);
        end else if (o == 7'b1101111) begin
            e = b; m = mb; e.srca = 2'd1; e.srcb = 2'd2; e.res = 2'd0; e.pc = 1'b1;
            m.srca = '1; m.srcb = '1; m.res = '1;
            push(e, m, name, n);
            e = b; m = mb; e.res = 2'd0; e.rw = 1'b1; m.res = '1;
            push(e, m, name, n);
        end else if (o == 7'b1100011) begin
            e = b; m = mb; e.srca = 2'd2; e.srcb = 2'd0; e.res = 2'd0;
            m.srca = '1; m.srcb = '1; m.res = '1;
            if (f3[2:1] == 2'b00)      e.alu = 4'd1;
            else if (f3[2:1] == 2'b10) e.alu = 4'd5;
            else if (f3[2:1] == 2'b11) e.alu = 4'd9;
            else                       m.alu = '0;
            e.pc = br_taken(f3, z[2]);
            push(e, m, name, n);
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [4:0] z, input string name);
        int n;
        op = o; funct3 = f3; funct7b5 = f7;
        plan(o, f3, f7, z, name, n);
        for (int k = 0; k < n; k++) begin
            Zero = z[k];
            @(posedge clk); #1;
        end
    endtask

    // Reset view: FETCH selects with every strobe held low.
    task automatic check_reset(input string tag);
        out_t e;
        e = '0;
        e.srcb = 2'd2; e.res = 2'd2; e.imm = imm_of(op);
        cmp(act, e, '1, tag);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL underflow: got DUT cycle with no expectation, want queued entry");
            end else begin
                cur = q.pop_front();
                cmp(act, cur.e, cur.m, cur.tag);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [0:5];
        logic [6:0] o;
        int n;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1101111; ops[5] = 7'b1100011;

        op = 7'b0000011;
        #1 check_reset("reset_init");
        @(posedge clk); #1 check_reset("reset_hold");
        @(negedge clk); #1 check_reset("reset_hold_neg");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_instr(7'b0000011, 3'd2, 1'b0, 5'b00000, "lw");
        run_instr(7'b0110011, 3'd0, 1'b1, 5'b00000, "sub");
        run_instr(7'b0010011, 3'd0, 1'b1, 5'b00000, "addi_f7");
        run_instr(7'b1100011, 3'd1, 1'b0, 5'b00000, "bne_nz");
        run_instr(7'b1100011, 3'd1, 1'b0, 5'b11111, "bne_z");
        run_instr(7'b1100011, 3'd7, 1'b0, 5'b00000, "bgeu_nz");
        run_instr(7'b1100011, 3'd7, 1'b0, 5'b11111, "bgeu_z");
        run_instr(7'b0110111, 3'd0, 1'b0, 5'b00000, "lui_illegal");
        run_instr(7'b0100011, 3'd2, 1'b0, 5'b00000, "sw");
        run_instr(7'b1101111, 3'd0, 1'b0, 5'b00000, "jal");

        // Abandon a load while it sits in MEMREAD.
        op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0;
        plan(op, funct3, funct7b5, 5'b00000, "lw_rst", n);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        #1 check_reset("rst_mid_memread");
        @(posedge clk); #1 check_reset("rst_mid_edge");
        @(negedge clk); #1 check_reset("rst_mid_neg");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 7) o = 7'($urandom);
            else                           o = ops[$urandom_range(0, 5)];
            run_instr(o, 3'($urandom), 1'($urandom), 5'($urandom), $sformatf("rnd%0d", i));
        end

        mon_en = 1'b0;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
